// File: rtl/ncsi_arb_pkg.sv
// Shared types for the NCSI egress arbiter:
// arbiter states, source ids and the AvST beat bundle.
package ncsi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    PT,
    DISCARD
  } arb_state_e;

  localparam logic SRC_RESP = 1'b0;
  localparam logic SRC_PT   = 1'b1;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        err;
  } beat_t;

  // Terminates a stalled packet mid-stream
  localparam beat_t ABORT_BEAT = '{
    data: 32'h0,
    sop:  1'b0,
    eop:  1'b1,
    mod:  2'd0,
    err:  1'b1
  };

endpackage

// File: rtl/ncsi_avst_skid.sv
// Two-entry AvST skid register; input ready
// depends only on registered occupancy.
module ncsi_avst_skid
  import ncsi_arb_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  beat_t in_beat,
  input  logic  in_vld,
  output logic  in_rdy,
  output beat_t out_beat,
  output logic  out_vld,
  input  logic  out_rdy
);

  beat_t      mem_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;
  logic       push;
  logic       pop;

  assign in_rdy   = (cnt_q != 2'd2);
  assign out_vld  = (cnt_q != 2'd0);
  assign out_beat = mem_q[rd_q];
  assign push     = in_vld & in_rdy;
  assign pop      = out_vld & out_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= in_beat;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/ncsi_tx_arb.sv
// NCSI egress arbiter: merges response/AEN and
// passthrough streams per packet toward the MAC.
module ncsi_tx_arb
  import ncsi_arb_pkg::*;
#(
  parameter int TIMEOUT_MS   = 8,
  parameter int PT_MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pulse_1ms,
  input  logic        package_en,
  input  logic        pt_tx_en,
  input  logic [31:0] b2a_nrtx_data,
  input  logic        b2a_nrtx_sop,
  input  logic        b2a_nrtx_eop,
  input  logic        b2a_nrtx_vld,
  input  logic [1:0]  b2a_nrtx_mod,
  input  logic        b2a_nrtx_err,
  input  logic        b2a_nrtx_rna,
  input  logic        b2a_nrtx_eb4sr,
  output logic        b2a_nrtx_rdy,
  output logic        b2a_nrtx_sent,
  input  logic [31:0] e2a_pttx_data,
  input  logic        e2a_pttx_sop,
  input  logic        e2a_pttx_eop,
  input  logic        e2a_pttx_err,
  input  logic        e2a_pttx_vld,
  input  logic [1:0]  e2a_pttx_mod,
  output logic        e2a_pttx_rdy,
  output logic [31:0] a2m_tx_data,
  output logic        a2m_tx_sop,
  output logic        a2m_tx_eop,
  output logic        a2m_tx_err,
  output logic        a2m_tx_vld,
  output logic [1:0]  a2m_tx_mod,
  input  logic        a2m_tx_rdy,
  output logic        arb_abort_pls,
  output logic        arb_abort_src
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       src_q;
  logic       src_d;
  logic       abort_src_q;
  logic [7:0] stall_q;
  logic [7:0] burst_q;

  beat_t resp_beat;
  beat_t pt_beat;
  beat_t src_beat;
  beat_t skid_in;
  beat_t skid_out;
  logic  skid_in_vld;
  logic  skid_in_rdy;
  logic  skid_out_vld;

  logic src_vld;
  logic src_acc;
  logic grant_rdy;
  logic drop_resp;
  logic drop_pt;
  logic resp_sop;
  logic pt_sop;
  logic pt_ok;
  logic flush_pt;
  logic fwd;
  logic tmo;
  logic sent;
  logic abort_pls;
  logic unused_rna;

  // rna only classifies the packet upstream
  assign unused_rna = b2a_nrtx_rna;

  assign resp_beat = '{
    data: b2a_nrtx_data,
    sop:  b2a_nrtx_sop,
    eop:  b2a_nrtx_eop,
    mod:  b2a_nrtx_mod,
    err:  b2a_nrtx_err
  };

  assign pt_beat = '{
    data: e2a_pttx_data,
    sop:  e2a_pttx_sop,
    eop:  e2a_pttx_eop,
    mod:  e2a_pttx_mod,
    err:  e2a_pttx_err
  };

  assign src_beat = src_q ? pt_beat : resp_beat;
  assign src_vld  = src_q ? e2a_pttx_vld : b2a_nrtx_vld;
  assign src_acc  = src_vld & grant_rdy;
  assign resp_sop = b2a_nrtx_vld & b2a_nrtx_sop;
  assign pt_sop   = e2a_pttx_vld & e2a_pttx_sop;
  assign pt_ok    = package_en & pt_tx_en;
  assign flush_pt = b2a_nrtx_eb4sr & pt_sop & pt_ok
                  & (burst_q < 8'(PT_MAX_BURST));
  assign fwd      = (state_q == RESP) | (state_q == PT);
  assign tmo      = fwd & (stall_q == 8'(TIMEOUT_MS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= SRC_RESP;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    unique case (state_q)
      IDLE: begin
        if (resp_sop && flush_pt) begin
          state_d = PT;
          src_d   = SRC_PT;
        end else if (resp_sop) begin
          state_d = RESP;
          src_d   = SRC_RESP;
        end else if (pt_sop && pt_ok) begin
          state_d = PT;
          src_d   = SRC_PT;
        end
      end
      RESP, PT: begin
        if (tmo) begin
          if (skid_in_rdy) state_d = DISCARD;
        end else if (src_acc && src_beat.eop) begin
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (src_vld && (src_beat.sop || src_beat.eop))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_rdy   = 1'b0;
    drop_resp   = 1'b0;
    drop_pt     = 1'b0;
    skid_in_vld = 1'b0;
    skid_in     = src_beat;
    sent        = 1'b0;
    abort_pls   = 1'b0;
    unique case (state_q)
      IDLE: begin
        drop_resp = b2a_nrtx_vld & ~b2a_nrtx_sop;
        drop_pt   = e2a_pttx_vld & ~e2a_pttx_sop;
      end
      RESP, PT: begin
        if (tmo) begin
          skid_in_vld = 1'b1;
          skid_in     = ABORT_BEAT;
          abort_pls   = skid_in_rdy;
        end else begin
          grant_rdy   = skid_in_rdy;
          skid_in_vld = src_vld;
          sent        = (state_q == RESP) & src_vld
                      & skid_in_rdy & src_beat.eop;
        end
      end
      // a new sop is left pending for IDLE
      DISCARD: grant_rdy = ~(src_vld & src_beat.sop);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q     <= 8'd0;
      burst_q     <= 8'd0;
      abort_src_q <= 1'b0;
    end else begin
      if (!fwd || src_acc)
        stall_q <= 8'd0;
      else if (pulse_1ms && !src_vld && !tmo)
        stall_q <= stall_q + 8'd1;
      if (state_q == IDLE && resp_sop && flush_pt)
        burst_q <= burst_q + 8'd1;
      else if (sent)
        burst_q <= 8'd0;
      if (abort_pls)
        abort_src_q <= src_q;
    end
  end

  ncsi_avst_skid u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_beat  (skid_in),
    .in_vld   (skid_in_vld),
    .in_rdy   (skid_in_rdy),
    .out_beat (skid_out),
    .out_vld  (skid_out_vld),
    .out_rdy  (a2m_tx_rdy)
  );

  assign b2a_nrtx_rdy  = drop_resp | (grant_rdy & (src_q == SRC_RESP));
  assign e2a_pttx_rdy  = drop_pt | (grant_rdy & (src_q == SRC_PT));
  assign b2a_nrtx_sent = sent;
  assign arb_abort_pls = abort_pls;
  assign arb_abort_src = abort_src_q;
  assign a2m_tx_data   = skid_out.data;
  assign a2m_tx_sop    = skid_out.sop;
  assign a2m_tx_eop    = skid_out.eop;
  assign a2m_tx_err    = skid_out.err;
  assign a2m_tx_mod    = skid_out.mod;
  assign a2m_tx_vld    = skid_out_vld;

endmodule

// File: tb/tb_ncsi_tx_arb.sv
// Bench for ncsi_tx_arb: packet table plus
// burst, timeout and backpressure sequences.
module tb_ncsi_tx_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pulse_1ms = 1'b0;
  logic        package_en = 1'b1;
  logic        pt_tx_en = 1'b1;
  logic [31:0] b2a_nrtx_data = '0;
  logic        b2a_nrtx_sop = 1'b0;
  logic        b2a_nrtx_eop = 1'b0;
  logic        b2a_nrtx_vld = 1'b0;
  logic [1:0]  b2a_nrtx_mod = '0;
  logic        b2a_nrtx_err = 1'b0;
  logic        b2a_nrtx_rna = 1'b0;
  logic        b2a_nrtx_eb4sr = 1'b0;
  logic        b2a_nrtx_rdy;
  logic        b2a_nrtx_sent;
  logic [31:0] e2a_pttx_data = '0;
  logic        e2a_pttx_sop = 1'b0;
  logic        e2a_pttx_eop = 1'b0;
  logic        e2a_pttx_err = 1'b0;
  logic        e2a_pttx_vld = 1'b0;
  logic [1:0]  e2a_pttx_mod = '0;
  logic        e2a_pttx_rdy;
  logic [31:0] a2m_tx_data;
  logic        a2m_tx_sop;
  logic        a2m_tx_eop;
  logic        a2m_tx_err;
  logic        a2m_tx_vld;
  logic [1:0]  a2m_tx_mod;
  logic        a2m_tx_rdy = 1'b1;
  logic        arb_abort_pls;
  logic        arb_abort_src;

  always #5 clk = ~clk;

  ncsi_tx_arb #(
    .TIMEOUT_MS   (8),
    .PT_MAX_BURST (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pulse_1ms      (pulse_1ms),
    .package_en     (package_en),
    .pt_tx_en       (pt_tx_en),
    .b2a_nrtx_data  (b2a_nrtx_data),
    .b2a_nrtx_sop   (b2a_nrtx_sop),
    .b2a_nrtx_eop   (b2a_nrtx_eop),
    .b2a_nrtx_vld   (b2a_nrtx_vld),
    .b2a_nrtx_mod   (b2a_nrtx_mod),
    .b2a_nrtx_err   (b2a_nrtx_err),
    .b2a_nrtx_rna   (b2a_nrtx_rna),
    .b2a_nrtx_eb4sr (b2a_nrtx_eb4sr),
    .b2a_nrtx_rdy   (b2a_nrtx_rdy),
    .b2a_nrtx_sent  (b2a_nrtx_sent),
    .e2a_pttx_data  (e2a_pttx_data),
    .e2a_pttx_sop   (e2a_pttx_sop),
    .e2a_pttx_eop   (e2a_pttx_eop),
    .e2a_pttx_err   (e2a_pttx_err),
    .e2a_pttx_vld   (e2a_pttx_vld),
    .e2a_pttx_mod   (e2a_pttx_mod),
    .e2a_pttx_rdy   (e2a_pttx_rdy),
    .a2m_tx_data    (a2m_tx_data),
    .a2m_tx_sop     (a2m_tx_sop),
    .a2m_tx_eop     (a2m_tx_eop),
    .a2m_tx_err     (a2m_tx_err),
    .a2m_tx_vld     (a2m_tx_vld),
    .a2m_tx_mod     (a2m_tx_mod),
    .a2m_tx_rdy     (a2m_tx_rdy),
    .arb_abort_pls  (arb_abort_pls),
    .arb_abort_src  (arb_abort_src)
  );

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        err;
    logic        eb4sr;
    logic [1:0]  mod;
  } sbeat_t;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        err;
    logic [1:0]  mod;
  } obeat_t;

  typedef struct {
    int rl;
    int pl;
    bit eb4sr;
    bit pten;
    bit pt_first;
  } vec_t;

  sbeat_t rq[$];
  sbeat_t pq[$];
  obeat_t exq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int sent_cnt = 0;
  int abort_cnt = 0;
  int acc_sop_cyc = -1;
  int out_sop_cyc = -1;
  int occ = 0;
  int occ_max = 0;
  bit mac_toggle = 0;
  bit pulse_req = 0;
  bit pt_seen_rdy = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic sbeat_t mk(int n, logic [31:0] base, bit eb4sr, int i);
    sbeat_t b;
    b.data  = base + 32'(i);
    b.sop   = (i == 0);
    b.eop   = (i == n - 1);
    b.err   = b.eop & base[0];
    b.mod   = b.eop ? 2'(n % 4) : 2'd0;
    b.eb4sr = eb4sr;
    return b;
  endfunction

  task automatic add_src(bit pt, int n, logic [31:0] base, bit eb4sr,
                         int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      if (pt) pq.push_back(mk(n, base, eb4sr, i));
      else rq.push_back(mk(n, base, eb4sr, i));
    end
  endtask

  task automatic add_exp(int n, logic [31:0] base, int lo, int hi);
    sbeat_t b;
    for (int i = lo; i < hi; i++) begin
      b = mk(n, base, 1'b0, i);
      exq.push_back('{b.data, b.sop, b.eop, b.err, b.mod});
    end
  endtask

  task automatic check_out();
    obeat_t e;
    n_cmp++;
    if (exq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_beat: got %h want none", a2m_tx_data);
      return;
    end
    e = exq.pop_front();
    if ({a2m_tx_data, a2m_tx_sop, a2m_tx_eop, a2m_tx_err, a2m_tx_mod}
        !== {e.data, e.sop, e.eop, e.err, e.mod}) begin
      n_bad++;
      $display("FAIL out_beat: got %h s%b e%b r%b m%0d want %h s%b e%b r%b m%0d",
               a2m_tx_data, a2m_tx_sop, a2m_tx_eop, a2m_tx_err, a2m_tx_mod,
               e.data, e.sop, e.eop, e.err, e.mod);
    end
  endtask

  task automatic drive();
    b2a_nrtx_vld = (rq.size() > 0);
    if (rq.size() > 0) begin
      b2a_nrtx_data  = rq[0].data;
      b2a_nrtx_sop   = rq[0].sop;
      b2a_nrtx_eop   = rq[0].eop;
      b2a_nrtx_err   = rq[0].err;
      b2a_nrtx_mod   = rq[0].mod;
      b2a_nrtx_eb4sr = rq[0].eb4sr;
      b2a_nrtx_rna   = 1'b1;
    end else begin
      b2a_nrtx_sop = 1'b0;
      b2a_nrtx_eop = 1'b0;
    end
    e2a_pttx_vld = (pq.size() > 0);
    if (pq.size() > 0) begin
      e2a_pttx_data = pq[0].data;
      e2a_pttx_sop  = pq[0].sop;
      e2a_pttx_eop  = pq[0].eop;
      e2a_pttx_err  = pq[0].err;
      e2a_pttx_mod  = pq[0].mod;
    end else begin
      e2a_pttx_sop = 1'b0;
      e2a_pttx_eop = 1'b0;
    end
    pulse_1ms = pulse_req;
    pulse_req = 0;
    a2m_tx_rdy = mac_toggle ? ~a2m_tx_rdy : 1'b1;
  endtask

  task automatic tick();
    bit ar, ap, ao;
    @(negedge clk);
    cyc++;
    ar = b2a_nrtx_vld && b2a_nrtx_rdy;
    ap = e2a_pttx_vld && e2a_pttx_rdy;
    ao = a2m_tx_vld && a2m_tx_rdy;
    if (e2a_pttx_rdy) pt_seen_rdy = 1;
    if (b2a_nrtx_sent) begin
      sent_cnt++;
      chk("sent_on_eop", 32'(ar && b2a_nrtx_eop), 32'd1);
    end
    if (arb_abort_pls) abort_cnt++;
    if (ar && b2a_nrtx_sop && acc_sop_cyc < 0) acc_sop_cyc = cyc;
    if (a2m_tx_vld && a2m_tx_sop && out_sop_cyc < 0) out_sop_cyc = cyc;
    if (ap) begin
      occ++;
      void'(pq.pop_front());
    end
    if (ar) void'(rq.pop_front());
    if (ao) begin
      occ--;
      check_out();
    end
    if (occ > occ_max) occ_max = occ;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(string name, bit need_pt);
    int n;
    n = 0;
    while ((exq.size() > 0 || rq.size() > 0 || (need_pt && pq.size() > 0))
           && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, 32'(n < 400), 32'd1);
    repeat (3) tick();
  endtask

  vec_t vt[7];

  initial begin
    int s0, a0;
    logic [31:0] rb, pb;

    vt[0] = '{3, 0, 1'b0, 1'b1, 1'b0};
    vt[1] = '{2, 3, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1, 1, 1'b0, 1'b1, 1'b0};
    vt[3] = '{2, 2, 1'b1, 1'b1, 1'b1};
    vt[4] = '{2, 2, 1'b1, 1'b0, 1'b0};
    vt[5] = '{0, 4, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1, 1, 1'b1, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(a2m_tx_vld), 32'd0);
    chk("rst_data", a2m_tx_data, 32'd0);
    chk("rst_rrdy", 32'(b2a_nrtx_rdy), 32'd0);
    chk("rst_prdy", 32'(e2a_pttx_rdy), 32'd0);
    chk("rst_sent", 32'(b2a_nrtx_sent), 32'd0);
    chk("rst_abort", 32'({arb_abort_pls, arb_abort_src}), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    foreach (vt[k]) begin
      rb = 32'hA000_0000 + 32'(k << 8) + 32'(k);
      pb = 32'hB000_0000 + 32'(k << 8) + 32'(k + 1);
      s0 = sent_cnt;
      acc_sop_cyc = -1;
      out_sop_cyc = -1;
      pt_tx_en = vt[k].pten;
      if (vt[k].rl > 0) add_src(0, vt[k].rl, rb, vt[k].eb4sr, 0, vt[k].rl);
      if (vt[k].pl > 0) add_src(1, vt[k].pl, pb, 1'b0, 0, vt[k].pl);
      if (vt[k].pt_first) begin
        add_exp(vt[k].pl, pb, 0, vt[k].pl);
        add_exp(vt[k].rl, rb, 0, vt[k].rl);
      end else begin
        add_exp(vt[k].rl, rb, 0, vt[k].rl);
        if (vt[k].pten) add_exp(vt[k].pl, pb, 0, vt[k].pl);
      end
      drain("vec", vt[k].pten);
      if (!vt[k].pten) begin
        chk("pt_blocked", pq.size(), vt[k].pl);
        pt_seen_rdy = 0;
        pt_tx_en = 1'b1;
        add_exp(vt[k].pl, pb, 0, vt[k].pl);
        tick();
        tick();
        chk("pt_grant_2cyc", 32'(pt_seen_rdy), 32'd1);
        drain("vec_pt", 1'b1);
      end
      chk("sent_count", sent_cnt - s0, 32'(vt[k].rl > 0));
      if (vt[k].rl > 0 && !vt[k].pt_first)
        chk("latency", out_sop_cyc - acc_sop_cyc, 32'd1);
    end

    // eb4sr flush: four passthrough, response, two more
    s0 = sent_cnt;
    for (int j = 0; j < 6; j++)
      add_src(1, 2, 32'hC000_0000 + 32'(j * 16), 1'b0, 0, 2);
    add_src(0, 3, 32'hD000_0001, 1'b1, 0, 3);
    for (int j = 0; j < 4; j++) add_exp(2, 32'hC000_0000 + 32'(j * 16), 0, 2);
    add_exp(3, 32'hD000_0001, 0, 3);
    for (int j = 4; j < 6; j++) add_exp(2, 32'hC000_0000 + 32'(j * 16), 0, 2);
    drain("burst", 1'b1);
    chk("burst_sent", sent_cnt - s0, 32'd1);

    // response stalls after two beats
    s0 = sent_cnt;
    a0 = abort_cnt;
    add_src(0, 5, 32'hE000_0000, 1'b0, 0, 2);
    add_exp(5, 32'hE000_0000, 0, 2);
    exq.push_back('{32'h0, 1'b0, 1'b1, 1'b1, 2'd0});
    repeat (4) tick();
    repeat (7) begin
      pulse_req = 1;
      tick();
      tick();
    end
    repeat (3) tick();
    chk("no_early_abort", abort_cnt - a0, 32'd0);
    pulse_req = 1;
    repeat (4) tick();
    chk("abort_resp_pls", abort_cnt - a0, 32'd1);
    chk("abort_resp_src", 32'(arb_abort_src), 32'd0);
    add_src(0, 5, 32'hE000_0000, 1'b0, 2, 5);
    drain("tmo_resp", 1'b0);
    chk("abort_no_sent", sent_cnt - s0, 32'd0);
    add_src(0, 2, 32'hE100_0000, 1'b0, 0, 2);
    add_exp(2, 32'hE100_0000, 0, 2);
    drain("after_abort", 1'b0);
    chk("after_abort_sent", sent_cnt - s0, 32'd1);

    // passthrough stalls; next sop ends the discard
    a0 = abort_cnt;
    add_src(1, 3, 32'hF000_0000, 1'b0, 0, 1);
    add_exp(3, 32'hF000_0000, 0, 1);
    exq.push_back('{32'h0, 1'b0, 1'b1, 1'b1, 2'd0});
    repeat (3) tick();
    repeat (8) begin
      pulse_req = 1;
      tick();
      tick();
    end
    repeat (3) tick();
    chk("abort_pt_pls", abort_cnt - a0, 32'd1);
    chk("abort_pt_src", 32'(arb_abort_src), 32'd1);
    add_src(1, 2, 32'hF100_0001, 1'b0, 0, 2);
    add_exp(2, 32'hF100_0001, 0, 2);
    drain("tmo_pt", 1'b1);

    // MAC ready toggling every cycle
    mac_toggle = 1;
    occ = 0;
    occ_max = 0;
    add_src(1, 10, 32'h7700_0000, 1'b0, 0, 10);
    add_exp(10, 32'h7700_0000, 0, 10);
    drain("toggle", 1'b1);
    chk("skid_occ_le2", 32'(occ_max <= 2), 32'd1);
    mac_toggle = 0;
    repeat (2) tick();

    chk("exq_empty", exq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
